// File: rtl/pe_types.sv
// Shared types for the PE delay-pipeline arbiter: config struct, id/pointer types,
// grant-counter width and drain FSM states.
package pe_types;

  localparam int PE_NUM_REQ      = 4;
  localparam int DELAY_ARB_CNT_W = 32;

  typedef logic [$clog2(PE_NUM_REQ)-1:0] req_id_t;
  typedef req_id_t                       rr_ptr_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } delay_arb_state_t;

  typedef struct packed {
    logic [7:0]  num_req;
    logic [7:0]  delay;
    logic [15:0] dev_id;
  } pe_cfg_t;

  localparam pe_cfg_t PE_CFG_DEFAULT = '{num_req: 8'd4, delay: 8'd8, dev_id: 16'h0001};

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin grant: first valid requester strictly after ptr,
// wrapping at NUM_REQ. Produces a one-hot (or zero) grant plus the granted id.
module rr_arb
  import pe_types::*;
#(
  parameter pe_cfg_t cfg     = PE_CFG_DEFAULT,
  parameter int      NUM_REQ = int'(cfg.num_req)
) (
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  input  logic                       i_en,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    o_grant = '0;
    o_id    = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(i_ptr) + i) % NUM_REQ);
      if (i_en && !found && i_valid[idx]) begin
        o_grant[idx] = 1'b1;
        o_id         = idx;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_arb.sv
// Round-robin scheduler feeding a fixed-latency tagged delay pipeline, with a drain FSM.
// Optional per-requester grant counters when DELAY_ARB_STATS_EN is defined.
//   state | meaning
//   RUN   | granting requests, pipeline flowing
//   DRAIN | grants stopped, waiting for in-flight responses to leave
//   IDLE  | pipeline empty, not granting, o_drain_done high
module delay_arb
  import pe_types::*;
#(
  parameter pe_cfg_t cfg     = PE_CFG_DEFAULT,
  parameter int      NUM_REQ = int'(cfg.num_req),
  parameter int      WIDTH   = 32,
  parameter int      DELAY   = int'(cfg.delay)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
  output logic [WIDTH-1:0]           o_rsp_data,
  input  logic                       i_drain_req,
`ifdef DELAY_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]      o_grant_cnt,
`endif
  output logic                       o_drain_done
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DELAY + 1);

  if (DELAY < 1) begin : g_bad_delay
    $fatal(1, "delay_arb: DELAY must be >= 1");
  end
  if (NUM_REQ < 2) begin : g_bad_num_req
    $fatal(1, "delay_arb: NUM_REQ must be >= 2");
  end

  delay_arb_state_t state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  logic             stg_vld_q  [DELAY];
  logic             stg_vld_d  [DELAY];
  logic [ID_W-1:0]  stg_id_q   [DELAY];
  logic [ID_W-1:0]  stg_id_d   [DELAY];
  logic [WIDTH-1:0] stg_data_q [DELAY];
  logic [WIDTH-1:0] stg_data_d [DELAY];

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_id;
  logic               arb_en;
  logic               accept;
  logic               rsp_valid;
  logic [WIDTH-1:0]   acc_data;

  // A drain request blocks the grant in the very cycle it is first seen.
  assign arb_en = (state_q == RUN) && !i_drain_req;

  rr_arb #(
    .cfg     (cfg),
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .i_valid (i_req_valid),
    .i_ptr   (ptr_q),
    .i_en    (arb_en),
    .o_grant (grant),
    .o_id    (gnt_id)
  );

  assign accept      = |grant;
  assign rsp_valid   = stg_vld_q[DELAY-1];
  assign o_req_ready = grant;
  assign o_rsp_valid = rsp_valid;
  assign o_rsp_id    = stg_id_q[DELAY-1];
  assign o_rsp_data  = stg_data_q[DELAY-1];
  assign o_drain_done = (state_q == IDLE);

  always_comb begin
    acc_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) acc_data = i_req_data[k*WIDTH +: WIDTH];
    end
  end

  // Empty slots carry zero id/data so the output is zero whenever it is invalid.
  always_comb begin
    stg_vld_d[0]  = accept;
    stg_id_d[0]   = accept ? gnt_id : '0;
    stg_data_d[0] = accept ? acc_data : '0;
    for (int k = 1; k < DELAY; k++) begin
      stg_vld_d[k]  = stg_vld_q[k-1];
      stg_id_d[k]   = stg_id_q[k-1];
      stg_data_d[k] = stg_data_q[k-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = accept ? gnt_id : ptr_q;
    inflight_d = inflight_q;
    case ({accept, rsp_valid})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    case (state_q)
      RUN:     if (i_drain_req) state_d = DRAIN;
      DRAIN:   if ((inflight_q == '0) && !rsp_valid) state_d = IDLE;
      IDLE:    if (!i_drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      inflight_q <= '0;
      for (int k = 0; k < DELAY; k++) begin
        stg_vld_q[k]  <= 1'b0;
        stg_id_q[k]   <= '0;
        stg_data_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      for (int k = 0; k < DELAY; k++) begin
        stg_vld_q[k]  <= stg_vld_d[k];
        stg_id_q[k]   <= stg_id_d[k];
        stg_data_q[k] <= stg_data_d[k];
      end
    end
  end

  a_inflight_ovf: assert property (@(posedge clock) disable iff (!reset_n)
    (accept && !rsp_valid) |-> (inflight_q != CNT_W'(DELAY)));
  a_inflight_udf: assert property (@(posedge clock) disable iff (!reset_n)
    (rsp_valid && !accept) |-> (inflight_q != '0));

`ifdef DELAY_ARB_STATS_EN
  logic [DELAY_ARB_CNT_W-1:0] gcnt_q [NUM_REQ];
  logic [DELAY_ARB_CNT_W-1:0] gcnt_d [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      gcnt_d[k] = gcnt_q[k];
      if (grant[k] && (gcnt_q[k] != '1)) gcnt_d[k] = gcnt_q[k] + DELAY_ARB_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REQ; k++) gcnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) gcnt_q[k] <= gcnt_d[k];
    end
  end

  always_comb begin
    o_grant_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) o_grant_cnt[k*32 +: 32] = gcnt_q[k];
  end
`endif

endmodule

// File: tb/tb_delay_arb.sv
// Scoreboard bench for delay_arb: random and directed stimulus, reference model of
// round-robin order, drain behaviour and response timing kept at transaction level.
module tb_delay_arb;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int M_RUN = 0, M_DRAIN = 1, M_IDLE = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     i_req_valid = '0;
  logic [NR*W-1:0]   i_req_data = '0;
  logic [NR-1:0]     o_req_ready;
  logic              o_rsp_valid;
  logic [1:0]        o_rsp_id;
  logic [W-1:0]      o_rsp_data;
  logic              i_drain_req = 1'b0;
  logic              o_drain_done;
`ifdef DELAY_ARB_STATS_EN
  logic [NR*32-1:0]  o_grant_cnt;
`endif

  delay_arb #(.NUM_REQ(NR), .WIDTH(W), .DELAY(D)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_req_valid  (i_req_valid),
    .i_req_data   (i_req_data),
    .o_req_ready  (o_req_ready),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_data   (o_rsp_data),
    .i_drain_req  (i_drain_req),
`ifdef DELAY_ARB_STATS_EN
    .o_grant_cnt  (o_grant_cnt),
`endif
    .o_drain_done (o_drain_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mode = M_RUN;
  int   last = NR - 1;
  int   gcnt [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Next requester after 'from' in circular order that has valid set; -1 if none.
  function automatic int rr_pick(input logic [NR-1:0] v, input int from);
    for (int i = 1; i <= NR; i++) begin
      if (v[(from + i) % NR]) return (from + i) % NR;
    end
    return -1;
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clock) begin
    logic [NR-1:0] exp_rdy;
    int            pick;
    int            pre_n;
    bit            exp_rsp;
    exp_t          e;
    cyc++;
    if (!reset_n) begin
      chk("rst_ready", o_req_ready, '0);
      chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_rsp_id", o_rsp_id, 0);
      chk("rst_rsp_data", o_rsp_data, 0);
      chk("rst_drain_done", o_drain_done, 0);
      sb.delete();
      mode = M_RUN;
      last = NR - 1;
      for (int k = 0; k < NR; k++) gcnt[k] = 0;
    end else begin
      pre_n   = sb.size();
      exp_rdy = '0;
      pick    = -1;
      if (mode == M_RUN && !i_drain_req) pick = rr_pick(i_req_valid, last);
      if (pick >= 0) exp_rdy[pick] = 1'b1;
      chk("ready", o_req_ready, exp_rdy);
      chk("drain_done", o_drain_done, mode == M_IDLE);
      exp_rsp = (sb.size() > 0) && (sb[0].due == cyc);
      chk("rsp_valid", o_rsp_valid, exp_rsp);
      if (exp_rsp) begin
        e = sb.pop_front();
        chk("rsp_id", o_rsp_id, e.id);
        chk("rsp_data", o_rsp_data, e.data);
      end else begin
        chk("rsp_id_idle", o_rsp_id, 0);
        chk("rsp_data_idle", o_rsp_data, 0);
      end
      if (pick >= 0) begin
        e.id   = 2'(pick);
        e.data = i_req_data[pick*W +: W];
        e.due  = cyc + D;
        sb.push_back(e);
        last = pick;
        gcnt[pick]++;
      end
      if (sb.size() > D) chk("inflight_bound", sb.size(), D);
      case (mode)
        M_RUN:   if (i_drain_req) mode = M_DRAIN;
        M_DRAIN: if (pre_n == 0) mode = M_IDLE;
        M_IDLE:  if (!i_drain_req) mode = M_RUN;
        default: mode = M_RUN;
      endcase
    end
  end

  // Inputs change 1 time unit after the rising edge; each call spans n cycles.
  task automatic step(input logic [NR-1:0] v, input logic dr, input int n, input bit rnd);
    repeat (n) begin
      i_req_valid = v;
      i_drain_req = dr;
      for (int k = 0; k < NR; k++) i_req_data[k*W +: W] = rnd ? W'($urandom) : W'(k);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic [NR-1:0] rv;
    logic          rdr;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Grant counters: 100 grants to req 0 then 50 to req 1.
    step(4'b0001, 1'b0, 100, 1'b1);
    step(4'b0010, 1'b0, 50, 1'b1);
    step(4'b0000, 1'b0, 12, 1'b0);
`ifdef DELAY_ARB_STATS_EN
    chk("gcnt0", o_grant_cnt[0*32 +: 32], 100);
    chk("gcnt1", o_grant_cnt[1*32 +: 32], 50);
    chk("gcnt2", o_grant_cnt[2*32 +: 32], 0);
    chk("gcnt3", o_grant_cnt[3*32 +: 32], 0);
`endif

    // All requesters valid, data = lane index.
    step(4'b1111, 1'b0, 20, 1'b0);
    step(4'b0000, 1'b0, 12, 1'b0);

    // Single requester, then two competing ones.
    step(4'b0100, 1'b0, 5, 1'b1);
    step(4'b1010, 1'b0, 2, 1'b1);
    step(4'b0000, 1'b0, 12, 1'b0);

    // Drain with 5 in flight, requests still pending.
    step(4'b1111, 1'b0, 5, 1'b1);
    step(4'b1111, 1'b1, 15, 1'b1);
    step(4'b1111, 1'b0, 4, 1'b1);
    // Drain request dropped while still draining: no early resume.
    step(4'b1111, 1'b1, 2, 1'b1);
    step(4'b1111, 1'b0, 14, 1'b1);
    step(4'b0000, 1'b0, 12, 1'b0);

    // Full rate: accept and response every cycle.
    step(4'b1111, 1'b0, 40, 1'b1);
    step(4'b0000, 1'b0, 12, 1'b0);

    // Reset while responses are leaving and 4 are still in flight.
    step(4'b1111, 1'b0, 12, 1'b1);
    step(4'b0000, 1'b0, 4, 1'b1);
    #2;
    i_req_valid = '0;
    reset_n = 1'b0;
    #1;
    chk("async_rsp_valid", o_rsp_valid, 0);
    chk("async_rsp_id", o_rsp_id, 0);
    chk("async_rsp_data", o_rsp_data, 0);
    chk("async_ready", o_req_ready, '0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    step(4'b0000, 1'b0, 20, 1'b0);

    // Random traffic with occasional drain toggles.
    rdr = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rv = NR'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) rdr = ~rdr;
      step(rv, rdr, 1, 1'b1);
    end
    step(4'b0000, 1'b0, 30, 1'b0);

    chk("sb_empty", sb.size(), 0);
`ifdef DELAY_ARB_STATS_EN
    for (int k = 0; k < NR; k++) chk("gcnt_final", o_grant_cnt[k*32 +: 32], gcnt[k]);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
